// File: rtl/vx_fetch_buffer.sv
// vx_fetch_buffer: fetch stage between the warp PC/mask generator and decode.
// Issues I-cache requests for the current PC, keeps request metadata in an
// in-order queue, pairs in-order responses with it and hands completed
// entries to decode. A redirect drops all queued and in-flight fetches.
// Optional build macro: VX_FETCH_PERF_EN adds fetch/stall/drop counters.
module vx_fetch_buffer #(
  parameter int NT    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   in_PC,
  input  logic [NT-1:0] in_valid,
  input  logic          in_flush,
  output logic          out_stall,
  output logic          out_icache_req_valid,
  output logic [31:0]   out_icache_req_addr,
  input  logic          in_icache_req_ready,
  input  logic          in_icache_rsp_valid,
  input  logic [31:0]   in_icache_rsp_data,
  output logic          out_valid,
  output logic [31:0]   out_PC,
  output logic [NT-1:0] out_thread_mask,
  output logic [31:0]   out_instr,
  input  logic          in_ready
`ifdef VX_FETCH_PERF_EN
  ,
  output logic [31:0]   out_perf_fetch_cnt,
  output logic [31:0]   out_perf_stall_cnt,
  output logic [31:0]   out_perf_drop_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [31:0]    pc_q    [DEPTH];
  logic [NT-1:0]  mask_q  [DEPTH];
  logic [31:0]    instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]  allocPtr_q, allocPtr_d;
  logic [AW-1:0]  fillPtr_q, fillPtr_d;
  logic [AW-1:0]  headPtr_q, headPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  dropCnt_q, dropCnt_d;

  logic           anyThread;
  logic           reqFire;
  logic           deqFire;
  logic [CW-1:0]  filledCnt;
  logic [CW-1:0]  unfilledCnt;
  logic           rspDrop;
  logic           rspFill;

  // Handshake decisions; every output is forced quiet while reset is held.
  always_comb begin
    anyThread            = |in_valid;
    out_icache_req_valid = anyThread && (count_q < DepthC) && (dropCnt_q == '0)
                           && !in_flush && !reset;
    out_icache_req_addr  = in_PC;
    reqFire              = out_icache_req_valid && in_icache_req_ready;
    out_stall            = anyThread && !reqFire && !reset;
    out_valid            = filled_q[headPtr_q] && !reset;
    out_PC               = pc_q[headPtr_q];
    out_thread_mask      = mask_q[headPtr_q];
    out_instr            = instr_q[headPtr_q];
    deqFire              = out_valid && in_ready;
  end

  // Filled entries are a subset of occupied ones, so the rest are still waiting on the I-cache.
  always_comb begin
    filledCnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filledCnt = filledCnt + CW'(filled_q[i]);
    end
    unfilledCnt = count_q - filledCnt;
    rspDrop     = in_icache_rsp_valid && (dropCnt_q != '0);
    rspFill     = in_icache_rsp_valid && (dropCnt_q == '0) && (unfilledCnt != '0);
  end

  // Next-state for pointers, occupancy, filled flags and the stale-response counter.
  always_comb begin
    allocPtr_d = allocPtr_q;
    fillPtr_d  = fillPtr_q;
    headPtr_d  = headPtr_q;
    filled_d   = filled_q;
    count_d    = count_q + CW'(reqFire) - CW'(deqFire);
    dropCnt_d  = dropCnt_q - CW'(rspDrop);
    if (deqFire) begin
      filled_d[headPtr_q] = 1'b0;
      headPtr_d           = headPtr_q + AW'(1);
    end
    if (reqFire) begin
      filled_d[allocPtr_q] = 1'b0;
      allocPtr_d           = allocPtr_q + AW'(1);
    end
    if (rspFill) begin
      filled_d[fillPtr_q] = 1'b1;
      fillPtr_d           = fillPtr_q + AW'(1);
    end
    if (in_flush) begin
      allocPtr_d = '0;
      fillPtr_d  = '0;
      headPtr_d  = '0;
      filled_d   = '0;
      count_d    = '0;
      // Outstanding responses still owed, minus any response consumed this very cycle
      // (a still-pending drop count is carried over so no stale word can slip through).
      dropCnt_d  = dropCnt_q + unfilledCnt - CW'(rspDrop || rspFill);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      allocPtr_q <= '0;
      fillPtr_q  <= '0;
      headPtr_q  <= '0;
      filled_q   <= '0;
      count_q    <= '0;
      dropCnt_q  <= '0;
    end else begin
      allocPtr_q <= allocPtr_d;
      fillPtr_q  <= fillPtr_d;
      headPtr_q  <= headPtr_d;
      filled_q   <= filled_d;
      count_q    <= count_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Payload storage; validity lives entirely in filled_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      pc_q[allocPtr_q]   <= in_PC;
      mask_q[allocPtr_q] <= in_valid;
    end
    if (rspFill && !in_flush) begin
      instr_q[fillPtr_q] <= in_icache_rsp_data;
    end
  end

`ifdef VX_FETCH_PERF_EN
  // Free-running event counters; a flush-cycle response is counted as discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_perf_fetch_cnt <= '0;
      out_perf_stall_cnt <= '0;
      out_perf_drop_cnt  <= '0;
    end else begin
      out_perf_fetch_cnt <= out_perf_fetch_cnt + 32'(deqFire);
      out_perf_stall_cnt <= out_perf_stall_cnt + 32'(out_stall);
      out_perf_drop_cnt  <= out_perf_drop_cnt + 32'(rspDrop || (in_flush && rspFill));
    end
  end
`endif

endmodule

// File: tb/tb_vx_fetch_buffer.sv
// tb_vx_fetch_buffer: cycle-by-cycle directed vectors for vx_fetch_buffer,
// followed by hand-written perf-counter and mid-operation reset sequences.
module tb_vx_fetch_buffer;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  mask;
    logic        flush;
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        inReady;
    logic        expReqValid;
    logic        expStall;
    logic        expValid;
    logic [31:0] expPC;
    logic [3:0]  expMask;
    logic [31:0] expInstr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] inPC;
  logic [3:0]  inValid;
  logic        inFlush;
  logic        outStall;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspData;
  logic        outValid;
  logic [31:0] outPC;
  logic [3:0]  outMask;
  logic [31:0] outInstr;
  logic        inReady;
`ifdef VX_FETCH_PERF_EN
  logic [31:0] perfFetch;
  logic [31:0] perfStall;
  logic [31:0] perfDrop;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  vx_fetch_buffer #(.NT(4), .DEPTH(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_PC                (inPC),
    .in_valid             (inValid),
    .in_flush             (inFlush),
    .out_stall            (outStall),
    .out_icache_req_valid (reqValid),
    .out_icache_req_addr  (reqAddr),
    .in_icache_req_ready  (reqReady),
    .in_icache_rsp_valid  (rspValid),
    .in_icache_rsp_data   (rspData),
    .out_valid            (outValid),
    .out_PC               (outPC),
    .out_thread_mask      (outMask),
    .out_instr            (outInstr),
    .in_ready             (inReady)
`ifdef VX_FETCH_PERF_EN
    ,
    .out_perf_fetch_cnt   (perfFetch),
    .out_perf_stall_cnt   (perfStall),
    .out_perf_drop_cnt    (perfDrop)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [31:0] pc, logic [3:0] mask, logic flush, logic rdy,
                              logic rv, logic [31:0] rd, logic ir, logic eReq, logic eStall,
                              logic eValid, logic [31:0] ePC, logic [3:0] eMask,
                              logic [31:0] eInstr);
    vec_t v;
    v.pc = pc; v.mask = mask; v.flush = flush; v.reqReady = rdy;
    v.rspValid = rv; v.rspData = rd; v.inReady = ir;
    v.expReqValid = eReq; v.expStall = eStall; v.expValid = eValid;
    v.expPC = ePC; v.expMask = eMask; v.expInstr = eInstr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    inPC     = v.pc;
    inValid  = v.mask;
    inFlush  = v.flush;
    reqReady = v.reqReady;
    rspValid = v.rspValid;
    rspData  = v.rspData;
    inReady  = v.inReady;
  endtask

  // Drive one row just after the rising edge, check mid-cycle, then advance a clock.
  task automatic runRow(input vec_t v, input int idx);
    applyStimulus(v);
    #4;
    checkOutput($sformatf("row%0d req_valid", idx), 32'(reqValid), 32'(v.expReqValid));
    checkOutput($sformatf("row%0d stall", idx), 32'(outStall), 32'(v.expStall));
    checkOutput($sformatf("row%0d out_valid", idx), 32'(outValid), 32'(v.expValid));
    if (v.expReqValid) checkOutput($sformatf("row%0d req_addr", idx), reqAddr, v.pc);
    if (v.expValid) begin
      checkOutput($sformatf("row%0d out_PC", idx), outPC, v.expPC);
      checkOutput($sformatf("row%0d out_mask", idx), 32'(outMask), 32'(v.expMask));
      checkOutput($sformatf("row%0d out_instr", idx), outInstr, v.expInstr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pc, mask, flush, reqRdy, rspV, rspData, inReady | eReq, eStall, eValid, ePC, eMask, eInstr
    // basic fetch: fire, response two cycles later, decode one cycle after that
    vecs.push_back(mk(32'h100, 4'b0001, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h100, 4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h100, 4'b0000, 0, 1, 1, 32'h00500093, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h100, 4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 1, 32'h100, 4'b0001, 32'h00500093));
    vecs.push_back(mk(32'h0,   4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    // full queue with decode blocked, then in-order drain
    vecs.push_back(mk(32'h0,   4'b1111, 0, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h4,   4'b1111, 0, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h8,   4'b1111, 0, 1, 1, 32'hAAAA0000, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h8,   4'b1111, 0, 1, 1, 32'hBBBB0004, 0, 0, 1, 1, 32'h0, 4'b1111, 32'hAAAA0000));
    vecs.push_back(mk(32'h8,   4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 1, 32'h0, 4'b1111, 32'hAAAA0000));
    vecs.push_back(mk(32'h8,   4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 1, 32'h4, 4'b1111, 32'hBBBB0004));
    // I-cache not ready: stall without allocation, idle warp: no stall
    vecs.push_back(mk(32'h40,  4'b0001, 0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h40,  4'b0001, 0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h40,  4'b0001, 0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h40,  4'b0000, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    // flush with two in flight, two responses discarded (rows 15..19 reused below)
    vecs.push_back(mk(32'h20,  4'b0001, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h24,  4'b0001, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h80,  4'b0001, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h80,  4'b0001, 0, 1, 1, 32'hDEAD0001, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h80,  4'b0001, 0, 1, 1, 32'hDEAD0002, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h80,  4'b0001, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h80,  4'b0000, 0, 1, 1, 32'h12345678, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h80,  4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 1, 32'h80, 4'b0001, 32'h12345678));
    // flush coincident with the first response
    vecs.push_back(mk(32'h20,  4'b0010, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h24,  4'b0010, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h24,  4'b0000, 1, 1, 1, 32'hCAFE0020, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0001, 0, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0001, 0, 1, 1, 32'hCAFE0024, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0001, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0000, 0, 1, 1, 32'h0000AB90, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 1, 32'h90, 4'b0001, 32'h0000AB90));
    // unexpected response on an empty queue is ignored
    vecs.push_back(mk(32'h90,  4'b0000, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h90,  4'b0000, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    applyStimulus(mk(32'h100, 4'b0001, 0, 1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    #2;
    checkOutput("reset out_valid", 32'(outValid), 32'h0);
    checkOutput("reset req_valid", 32'(reqValid), 32'h0);
    checkOutput("reset stall", 32'(outStall), 32'h0);
`ifdef VX_FETCH_PERF_EN
    checkOutput("reset perf_fetch", perfFetch, 32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) runRow(vecs[i], i);

`ifdef VX_FETCH_PERF_EN
    // Fresh reset, replay the two-in-flight flush scenario, inspect counters.
    reset = 1'b1;
    applyStimulus(mk(32'h0, 4'b0000, 0, 1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 15; i < 20; i++) runRow(vecs[i], 100 + i);
    checkOutput("perf drop after flush", perfDrop, 32'd2);
    checkOutput("perf fetch after flush", perfFetch, 32'd0);
    checkOutput("perf stall after flush", perfStall, 32'd3);
`endif

    // Entry waiting at decode when reset hits mid-cycle.
    runRow(mk(32'h200, 4'b0001, 0, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0), 200);
    runRow(mk(32'h200, 4'b0000, 0, 1, 1, 32'h11112222, 0, 0, 0, 0, 0, 0, 0), 201);
    applyStimulus(mk(32'h204, 4'b0001, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    #4;
    checkOutput("pre-reset out_valid", 32'(outValid), 32'h1);
    checkOutput("pre-reset out_PC", outPC, 32'h200);
    checkOutput("pre-reset out_instr", outInstr, 32'h11112222);
    checkOutput("pre-reset stall", 32'(outStall), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mid-reset out_valid", 32'(outValid), 32'h0);
    checkOutput("mid-reset stall", 32'(outStall), 32'h0);
    checkOutput("mid-reset req_valid", 32'(reqValid), 32'h0);
`ifdef VX_FETCH_PERF_EN
    checkOutput("mid-reset perf_fetch", perfFetch, 32'h0);
    checkOutput("mid-reset perf_stall", perfStall, 32'h0);
    checkOutput("mid-reset perf_drop", perfDrop, 32'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    runRow(mk(32'h204, 4'b0000, 0, 1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0), 202);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
